// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR user-interface arbiters.
package ddr_arb_pkg;

  localparam int DDR_ADDR_BITS = 29;
  localparam int DDR_DATA_BITS = 128;
  localparam logic [2:0] DDR_CMD_WRITE = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin encoder: returns the first requester found when
// scanning upward from last_grant+1, wrapping modulo NUM_PORTS.
module rr_priority_select #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_BITS  = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_BITS-1:0]  last_grant,
  output logic [IDX_BITS-1:0]  grant,
  output logic                 grant_valid
);

  logic [IDX_BITS-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = IDX_BITS'((int'(last_grant) + i) % NUM_PORTS);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_write_arbiter.sv
// Round-robin write arbiter in front of the DDR controller user interface.
// Each grant becomes one write command plus one full-width data beat, then a
// single-cycle ack back to the granted source.
module ddr_write_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_BITS = DDR_ADDR_BITS,
  parameter int DATA_BITS = DDR_DATA_BITS
) (
  input  logic                           clk_ram,
  input  logic                           rst,
  input  logic                           ram_ready,
  input  logic [NUM_PORTS-1:0]           port_wr_en,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] port_wr_addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0] port_wr_data,
  output logic [NUM_PORTS-1:0]           port_wr_ack,
  output logic                           app_en,
  output logic [2:0]                     app_cmd,
  output logic [ADDR_BITS-1:0]           app_addr,
  input  logic                           app_rdy,
  output logic                           app_wdf_wren,
  output logic [DATA_BITS-1:0]           app_wdf_data,
  output logic                           app_wdf_end,
  output logic [DATA_BITS/8-1:0]         app_wdf_mask,
  input  logic                           app_wdf_rdy,
  output logic [31:0]                    perf_writes
);

  localparam int IDX_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t          state;
  logic [IDX_BITS-1:0] last_grant;
  logic [IDX_BITS-1:0] grant;
  logic [IDX_BITS-1:0] sel;
  logic                sel_valid;
  logic                cmd_done;
  logic                data_done;
  logic                cmd_now;
  logic                data_now;

  rr_priority_select #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_BITS (IDX_BITS)
  ) u_select (
    .req        (port_wr_en),
    .last_grant (last_grant),
    .grant      (sel),
    .grant_valid(sel_valid)
  );

  // Handshake completions happening in the current cycle.
  assign cmd_now      = app_en & app_rdy;
  assign data_now     = app_wdf_wren & app_wdf_rdy;

  // Fixed command fields: writes only, single-beat bursts, no byte masking.
  assign app_cmd      = DDR_CMD_WRITE;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  // Arbitration FSM with all interface outputs registered.
  // NOTE: reset is synchronous here because the controller clock domain resets that way.
  always_ff @(posedge clk_ram) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDX_BITS'(NUM_PORTS - 1);
      grant        <= '0;
      cmd_done     <= 1'b0;
      data_done    <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      port_wr_ack  <= '0;
      perf_writes  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (ram_ready && sel_valid) begin
            grant        <= sel;
            app_addr     <= port_wr_addr[sel*ADDR_BITS +: ADDR_BITS];
            app_wdf_data <= port_wr_data[sel*DATA_BITS +: DATA_BITS];
            app_en       <= 1'b1;
            app_wdf_wren <= 1'b1;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_now) begin
            app_en   <= 1'b0;
            cmd_done <= 1'b1;
          end
          if (data_now) begin
            app_wdf_wren <= 1'b0;
            data_done    <= 1'b1;
          end
          if ((cmd_done || cmd_now) && (data_done || data_now)) begin
            port_wr_ack <= NUM_PORTS'(1) << grant;
            state       <= ACK;
          end
        end
        ACK: begin
          port_wr_ack <= '0;
          perf_writes <= perf_writes + 32'd1;
          last_grant  <= grant;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Self-checking bench for ddr_write_arbiter: bench-side sources issue writes
// and queue what they sent; a negedge monitor predicts each grant from the
// round-robin rule and compares the issued command, data and ack.
module tb_ddr_write_arbiter;

  localparam int NP = 2;
  localparam int AB = 29;
  localparam int DB = 128;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } item_t;

  logic             clk_ram = 1'b0;
  logic             rst = 1'b1;
  logic             ram_ready = 1'b1;
  logic [NP-1:0]    port_wr_en = '0;
  logic [NP*AB-1:0] port_wr_addr = '0;
  logic [NP*DB-1:0] port_wr_data = '0;
  logic [NP-1:0]    port_wr_ack;
  logic             app_en;
  logic [2:0]       app_cmd;
  logic [AB-1:0]    app_addr;
  logic             app_rdy = 1'b1;
  logic             app_wdf_wren;
  logic [DB-1:0]    app_wdf_data;
  logic             app_wdf_end;
  logic [DB/8-1:0]  app_wdf_mask;
  logic             app_wdf_rdy = 1'b1;
  logic [31:0]      perf_writes;

  ddr_write_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk_ram     (clk_ram),
    .rst         (rst),
    .ram_ready   (ram_ready),
    .port_wr_en  (port_wr_en),
    .port_wr_addr(port_wr_addr),
    .port_wr_data(port_wr_data),
    .port_wr_ack (port_wr_ack),
    .app_en      (app_en),
    .app_cmd     (app_cmd),
    .app_addr    (app_addr),
    .app_rdy     (app_rdy),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_data(app_wdf_data),
    .app_wdf_end (app_wdf_end),
    .app_wdf_mask(app_wdf_mask),
    .app_wdf_rdy (app_wdf_rdy),
    .perf_writes (perf_writes)
  );

  always #5 clk_ram = ~clk_ram;

  int cyc = 0;
  always @(posedge clk_ram) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- sources ----------------
  item_t         exp_q[NP][$];
  logic [NP-1:0] busy = '0;
  logic [NP-1:0] src_en = '0;
  logic [NP-1:0] ack_l = '0;
  int            req_pct = 0;
  int            rdy_mode = 0;    // 0 tied high, 1 random, 2 scripted by main
  int            ready_mode = 0;  // 0 scripted by main, 1 random

  always @(negedge clk_ram) ack_l = port_wr_ack;

  task automatic issue(input int p, input logic [AB-1:0] a, input logic [DB-1:0] d);
    item_t it;
    it.addr = a;
    it.data = d;
    port_wr_addr[p*AB +: AB] = a;
    port_wr_data[p*DB +: DB] = d;
    port_wr_en[p] = 1'b1;
    busy[p] = 1'b1;
    exp_q[p].push_back(it);
  endtask

  task automatic step();
    @(posedge clk_ram);
    #1;
    if (rdy_mode == 1) begin
      app_rdy     = ($urandom_range(3) != 0);
      app_wdf_rdy = ($urandom_range(3) != 0);
    end else if (rdy_mode == 0) begin
      app_rdy     = 1'b1;
      app_wdf_rdy = 1'b1;
    end
    if (ready_mode == 1) ram_ready = ($urandom_range(9) != 0);
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        if (busy[p] && ack_l[p]) begin
          busy[p] = 1'b0;
          port_wr_en[p] = 1'b0;
        end
        if (!busy[p] && src_en[p] && ($urandom_range(99) < req_pct))
          issue(p, AB'($urandom), {$urandom, $urandom, $urandom, $urandom});
      end
    end
  endtask

  // ---------------- monitor / reference model ----------------
  bit            in_txn = 0;
  int            exp_port = 0;
  int            ncmd = 0;
  int            ndata = 0;
  int            last_acc = 0;
  int            ack_cnt = 0;
  int            last_ack_cyc = 0;
  bit            spacing_on = 0;
  bit            spacing_armed = 0;
  logic [31:0]   model_writes = 0;
  int            model_last = NP - 1;
  logic [NP-1:0] prev_req = '0;
  logic          prev_ready = 1'b0;
  logic          prev_ack = 1'b0;
  logic          prev_rst = 1'b1;
  logic [AB-1:0] cap_addr = '0;
  logic [DB-1:0] cap_data = '0;
  item_t         got;

  // Round-robin rule: first requester after the last granted port, wrapping.
  function automatic int rr_pick(input logic [NP-1:0] req, input int last);
    for (int i = 1; i <= NP; i++) begin
      if (req[(last + i) % NP]) return (last + i) % NP;
    end
    return -1;
  endfunction

  always @(negedge clk_ram) begin
    if (rst) begin
      in_txn = 0;
      ncmd = 0;
      ndata = 0;
      ack_cnt = 0;
      model_last = NP - 1;
      model_writes = 0;
    end else begin
      if (!in_txn && !prev_ack && !prev_rst)
        check("grant_decision", (app_en || app_wdf_wren),
              (prev_ready && (prev_req != 0)));
      if (!in_txn && (app_en || app_wdf_wren)) begin
        in_txn = 1;
        exp_port = rr_pick(prev_req, model_last);
        ncmd = 0;
        ndata = 0;
      end
      if (app_en && app_rdy) begin
        ncmd++;
        cap_addr = app_addr;
        last_acc = cyc;
        check("cmd_is_write", app_cmd, 3'b000);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        ndata++;
        cap_data = app_wdf_data;
        last_acc = cyc;
        check("wdf_end_mask", {app_wdf_end, app_wdf_mask}, {1'b1, 16'h0000});
      end
      if (port_wr_ack != 0) begin
        check("ack_in_txn", in_txn, 1'b1);
        if (in_txn && exp_port >= 0) begin
          check("ack_port", port_wr_ack, NP'(1) << exp_port);
          if (exp_q[exp_port].size() > 0) begin
            got = exp_q[exp_port].pop_front();
            check("cmd_addr", cap_addr, got.addr);
            check("wdf_data", cap_data, got.data);
          end else begin
            check("ack_has_request", 1'b0, 1'b1);
          end
          check("one_cmd_one_beat", {ncmd[7:0], ndata[7:0]}, 16'h0101);
          check("ack_latency", cyc - last_acc, 1);
          check("perf_at_ack", perf_writes, model_writes);
          if (spacing_on) begin
            if (spacing_armed) check("ack_spacing", cyc - last_ack_cyc, 3);
            spacing_armed = 1;
          end
          last_ack_cyc = cyc;
          model_writes = model_writes + 32'd1;
          model_last = exp_port;
        end
        in_txn = 0;
        ack_cnt++;
      end
    end
    prev_req   = port_wr_en;
    prev_ready = ram_ready;
    prev_ack   = (port_wr_ack != 0);
    prev_rst   = rst;
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    port_wr_en = '0;
    busy = '0;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string name, input int limit);
    int n = 0;
    while (!(app_en || app_wdf_wren) && n < limit) begin
      step();
      n++;
    end
    check(name, (app_en || app_wdf_wren), 1'b1);
  endtask

  task automatic wait_acks(input string name, input int target, input int limit);
    int n = 0;
    while (ack_cnt < target && n < limit) begin
      step();
      n++;
    end
    check(name, (ack_cnt >= target), 1'b1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    src_en = '0;
    ram_ready = 1'b1;
    rdy_mode = 0;
    while ((busy != 0 || in_txn) && n < 100) begin
      step();
      n++;
    end
    check(name, ((busy == 0) && !in_txn), 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int base;

    // Reset values
    do_reset(3);
    @(negedge clk_ram);
    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", app_wdf_wren, 1'b0);
    check("rst_wdf_end", app_wdf_end, 1'b0);
    check("rst_ack", port_wr_ack, '0);
    check("rst_addr", app_addr, '0);
    check("rst_data", app_wdf_data, '0);
    check("rst_perf", perf_writes, 32'd0);

    // No grant while the controller is not calibrated
    ram_ready = 1'b0;
    step();
    issue(0, 29'h100, {4{32'hA5A5_0100}});
    cnt = 0;
    repeat (50) begin
      step();
      if (app_en) cnt++;
    end
    check("no_cmd_while_not_ready", cnt, 0);
    ram_ready = 1'b1;
    wait_start("start_after_ready", 4);
    check("addr_after_ready", app_addr, 29'h100);
    wait_acks("ack_after_ready", 1, 10);
    drain("drain_ready");

    // Continuous requests from both ports with ready lines tied high
    do_reset(2);
    spacing_on = 1;
    spacing_armed = 0;
    src_en = '1;
    req_pct = 100;
    wait_acks("alternate_acks", 8, 60);
    check("perf_after_8", perf_writes, 32'd8);
    spacing_on = 0;
    drain("drain_alternate");

    // Data accepted first, command held off for 5 cycles
    rdy_mode = 2;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b1;
    base = ack_cnt;
    issue(0, AB'($urandom), {$urandom, $urandom, $urandom, $urandom});
    wait_start("start_cmd_stall", 5);
    repeat (5) step();
    check("wren_dropped_after_beat", {app_en, app_wdf_wren}, 2'b10);
    app_rdy = 1'b1;
    wait_acks("ack_cmd_stall", base + 1, 5);

    // Command accepted first, data held off
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b0;
    step();
    base = ack_cnt;
    issue(1, AB'($urandom), {$urandom, $urandom, $urandom, $urandom});
    wait_start("start_data_stall", 5);
    repeat (5) step();
    check("en_dropped_after_cmd", {app_en, app_wdf_wren}, 2'b01);
    app_wdf_rdy = 1'b1;
    wait_acks("ack_data_stall", base + 1, 5);

    // Both held off, then released together
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    step();
    base = ack_cnt;
    issue(0, AB'($urandom), {$urandom, $urandom, $urandom, $urandom});
    wait_start("start_both_stall", 5);
    repeat (3) step();
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    wait_acks("ack_both_release", base + 1, 5);
    drain("drain_stalls");

    // Reset in the middle of an issued write drops it without ack
    rdy_mode = 2;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    issue(1, AB'($urandom), {$urandom, $urandom, $urandom, $urandom});
    wait_start("start_before_reset", 5);
    repeat (2) step();
    do_reset(1);
    @(negedge clk_ram);
    check("midrst_outputs", {app_en, app_wdf_wren, port_wr_ack}, '0);
    check("midrst_perf", perf_writes, 32'd0);
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (10) step();
    check("midrst_no_ack", ack_cnt, 0);
    rdy_mode = 0;

    // Counter wrap from all-ones
    repeat (3) step();
    force dut.perf_writes = 32'hFFFF_FFFF;
    step();
    release dut.perf_writes;
    model_writes = 32'hFFFF_FFFF;
    step();
    check("perf_preload", perf_writes, 32'hFFFF_FFFF);
    base = ack_cnt;
    issue(1, AB'($urandom), {$urandom, $urandom, $urandom, $urandom});
    wait_acks("ack_wrap", base + 1, 10);
    step();
    check("perf_wrapped", perf_writes, 32'd0);

    // Randomized traffic, random ready lines and calibration drops
    src_en = '1;
    req_pct = 30;
    rdy_mode = 1;
    ready_mode = 1;
    repeat (1500) step();
    ready_mode = 0;
    drain("drain_random");
    check("random_made_progress", (ack_cnt > 50), 1'b1);
    for (int p = 0; p < NP; p++) check("queue_empty", exp_q[p].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
